// File: rtl/onchip_mem_copy_engine_if.sv
// Avalon-MM bus between the copy engine (master) and its single-port on-chip RAM (slave).
interface onchip_mem_copy_engine_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_mem_copy_engine.sv
// Word copy engine for a latency-1 on-chip RAM: RD -> LAT -> WR per word.
// Optional COPY_ENGINE_CHECKSUM_EN adds a running sum of the copied words.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RD    | read issued at src
// LAT   | read data returning; captured at the closing edge
// WR    | captured word written to dst; counters advance
// DONE  | one-cycle completion pulse
module onchip_mem_copy_engine #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [LEN_W-1:0]     word_count,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     words_done,
`ifdef COPY_ENGINE_CHECKSUM_EN
  output logic [DATA_W-1:0]    checksum,
`endif
  onchip_mem_copy_engine_if.master mem
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAT  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state, state_nxt;
  logic              accept;
  logic [ADDR_W-1:0] src_q, src_nxt;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              busy_nxt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        // abort has priority over a coincident start
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = (word_count == '0) ? S_DONE : S_RD;
        end
      end
      S_RD:   state_nxt = abort ? S_IDLE : S_LAT;
      S_LAT:  state_nxt = abort ? S_IDLE : S_WR;
      S_WR: begin
        if (abort)
          state_nxt = S_IDLE;
        else if (remaining_q == LEN_W'(1))
          state_nxt = S_DONE;
        else
          state_nxt = S_RD;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    src_nxt = src_q;
    if (accept)
      src_nxt = src_addr;
    else if (state == S_WR)
      src_nxt = src_q + 1'b1;
  end

  assign busy_nxt = (state_nxt == S_RD) || (state_nxt == S_LAT) || (state_nxt == S_WR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      remaining_q    <= '0;
      words_done     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem.address    <= '0;
      mem.byteenable <= '0;
      mem.chipselect <= 1'b0;
      mem.write      <= 1'b0;
      mem.writedata  <= '0;
      mem.clken      <= 1'b0;
`ifdef COPY_ENGINE_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      state <= state_nxt;
      src_q <= src_nxt;

      // a WR in flight when abort arrives still lands, so it is counted
      if (accept) begin
        dst_q       <= dst_addr;
        remaining_q <= word_count;
        words_done  <= '0;
      end else if (state == S_WR) begin
        dst_q       <= dst_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
        words_done  <= words_done + 1'b1;
      end

      if (state == S_LAT && !abort)
        mem.writedata <= mem.readdata;

`ifdef COPY_ENGINE_CHECKSUM_EN
      if (accept)
        checksum <= '0;
      else if (state == S_LAT && !abort)
        checksum <= checksum + mem.readdata;
`endif

      busy           <= busy_nxt;
      mem.clken      <= busy_nxt;
      done           <= (state_nxt == S_DONE);
      mem.chipselect <= (state_nxt == S_RD) || (state_nxt == S_WR);
      mem.write      <= (state_nxt == S_WR);
      mem.byteenable <= ((state_nxt == S_RD) || (state_nxt == S_WR)) ? '1 : '0;

      if (state_nxt == S_RD)
        mem.address <= src_nxt;
      else if (state_nxt == S_WR)
        mem.address <= dst_q;
    end
  end

endmodule

// File: tb/tb_onchip_mem_copy_engine.sv
// Directed bench for onchip_mem_copy_engine with a latency-1 byte-enabled RAM model.
module tb_onchip_mem_copy_engine;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;
`ifdef COPY_ENGINE_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  onchip_mem_copy_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  onchip_mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
`ifdef COPY_ENGINE_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .mem        (mem_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model; preloads go through the same process that performs writes
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [DATA_W/8-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < DATA_W/8; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (pl_en)
      ram[pl_addr] <= pl_data;
    else if (mem_bus.clken && mem_bus.chipselect) begin
      if (mem_bus.write)
        ram[mem_bus.address] <= merge(ram[mem_bus.address], mem_bus.writedata, mem_bus.byteenable);
      else
        mem_bus.readdata <= ram[mem_bus.address];
    end
  end

  int                cs_edges   = 0;
  int                done_edges = 0;
  logic [ADDR_W-1:0] rd_log [$];

  always @(posedge clk) begin
    if (mem_bus.chipselect) cs_edges <= cs_edges + 1;
    if (done) done_edges <= done_edges + 1;
    if (mem_bus.chipselect && mem_bus.clken && !mem_bus.write)
      rd_log.push_back(mem_bus.address);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic start_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                            input logic [LEN_W-1:0] c);
    src_addr   = s;
    dst_addr   = d;
    word_count = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(output int nbusy, output bit got);
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  int nbusy;
  bit got;
  int cs0, done0, q0;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; pl_en = 1'b0;
    pl_addr = '0; pl_data = '0;
    src_addr = '0; dst_addr = '0; word_count = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, words_done, mem_bus.chipselect, mem_bus.write,
                            mem_bus.clken, mem_bus.address}, '0);
    reset = 1'b0;
    @(negedge clk);

    // 4-word copy
    for (int i = 0; i < 4; i++) preload(ADDR_W'(16 + i), 32'hA0A0_0000 + DATA_W'(i));
    done0 = done_edges;
    start_copy(15'h0010, 15'h0100, 16'd4);
    check("t1_busy_start", {busy, mem_bus.clken, mem_bus.chipselect, mem_bus.address}, {3'b111, 15'h0010});
    check("t1_byteenable", mem_bus.byteenable, 4'hF);
    wait_done(nbusy, got);
    check("t1_done_seen", got, 1'b1);
    check("t1_busy_cycles", nbusy, 12);
    check("t1_busy_low_at_done", busy, 1'b0);
    @(negedge clk);
    check("t1_done_one_cycle", done, 1'b0);
    check("t1_done_count", done_edges - done0, 1);
    check("t1_words_done", words_done, 16'd4);
    for (int i = 0; i < 4; i++)
      check("t1_ram", ram[15'h0100 + ADDR_W'(i)], 32'hA0A0_0000 + DATA_W'(i));

    // zero-length copy
    cs0 = cs_edges;
    start_copy(15'h0010, 15'h0180, 16'd0);
    check("t2_done_now", {done, busy}, 2'b10);
    @(negedge clk);
    check("t2_done_drop", {done, busy}, 2'b00);
    check("t2_no_chipselect", cs_edges - cs0, 0);
    check("t2_words_done", words_done, 16'd0);

    // address wrap, plus a start issued mid-copy that must be ignored
    preload(15'h7FFE, 32'hB000_0000);
    preload(15'h7FFF, 32'hB000_0001);
    preload(15'h0000, 32'hB000_0002);
    preload(15'h0001, 32'hB000_0003);
    q0 = rd_log.size();
    done0 = done_edges;
    start_copy(15'h7FFE, 15'h0200, 16'd4);
    @(negedge clk);
    start_copy(15'h0010, 15'h0280, 16'd0);
    wait_done(nbusy, got);
    check("t3_done_seen", got, 1'b1);
    @(negedge clk);
    check("t3_read_count", rd_log.size() - q0, 4);
    check("t3_rd0", rd_log[q0],     15'h7FFE);
    check("t3_rd1", rd_log[q0 + 1], 15'h7FFF);
    check("t3_rd2", rd_log[q0 + 2], 15'h0000);
    check("t3_rd3", rd_log[q0 + 3], 15'h0001);
    for (int i = 0; i < 4; i++)
      check("t3_ram", ram[15'h0200 + ADDR_W'(i)], 32'hB000_0000 + DATA_W'(i));
    check("t3_words_done", words_done, 16'd4);
    check("t3_single_done", done_edges - done0, 1);

    // abort during the write of the second word
    for (int i = 0; i < 8; i++) begin
      preload(ADDR_W'(32 + i), 32'hC0C0_0000 + DATA_W'(i));
      preload(15'h0300 + ADDR_W'(i), 32'hDEAD_0000 + DATA_W'(i));
    end
    done0 = done_edges;
    start_copy(15'h0020, 15'h0300, 16'd8);
    repeat (5) @(negedge clk);
    check("t4_in_wr", {mem_bus.write, mem_bus.address}, {1'b1, 15'h0301});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_idle_after_abort", {busy, done, mem_bus.chipselect}, 3'b000);
    check("t4_words_done", words_done, 16'd2);
    repeat (3) @(negedge clk);
    check("t4_no_done", done_edges - done0, 0);
    check("t4_ram0", ram[15'h0300], 32'hC0C0_0000);
    check("t4_ram1", ram[15'h0301], 32'hC0C0_0001);
    check("t4_ram2_kept", ram[15'h0302], 32'hDEAD_0002);
    check("t4_ram3_kept", ram[15'h0303], 32'hDEAD_0003);

    // start and abort together: abort wins
    cs0 = cs_edges;
    abort = 1'b1;
    start_copy(15'h0020, 15'h0380, 16'd4);
    abort = 1'b0;
    @(negedge clk);
    check("t4b_start_abort", {busy, done}, 2'b00);
    check("t4b_no_access", cs_edges - cs0, 0);

    // reset during LAT of word 3 of 6
    for (int i = 0; i < 6; i++) begin
      preload(ADDR_W'(80 + i), 32'hE0E0_0000 + DATA_W'(i));
      preload(15'h0400 + ADDR_W'(i), 32'h5555_0000 + DATA_W'(i));
    end
    start_copy(15'h0050, 15'h0400, 16'd6);
    repeat (7) @(negedge clk);
    check("t5_in_lat", {busy, mem_bus.chipselect}, 2'b10);
    reset = 1'b1;
    #1;
    check("t5_status_zero", {busy, done, words_done}, '0);
    check("t5_bus_zero", {mem_bus.address, mem_bus.byteenable, mem_bus.chipselect,
                          mem_bus.write, mem_bus.clken}, '0);
    check("t5_writedata_zero", mem_bus.writedata, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_ram0", ram[15'h0400], 32'hE0E0_0000);
    check("t5_ram1", ram[15'h0401], 32'hE0E0_0001);
    check("t5_ram2_kept", ram[15'h0402], 32'h5555_0002);
    preload(15'h0060, 32'h1234_5678);
    preload(15'h0061, 32'h9ABC_DEF0);
    start_copy(15'h0060, 15'h0500, 16'd2);
    wait_done(nbusy, got);
    check("t5_fresh_done", got, 1'b1);
    check("t5_fresh_busy", nbusy, 6);
    @(negedge clk);
    check("t5_fresh_words", words_done, 16'd2);
    check("t5_fresh_ram0", ram[15'h0500], 32'h1234_5678);
    check("t5_fresh_ram1", ram[15'h0501], 32'h9ABC_DEF0);

    // overlapping forward copy: dst = src + 1 smears the first word
    preload(15'h0040, 32'hD000_0000);
    preload(15'h0041, 32'hD000_0001);
    preload(15'h0042, 32'hD000_0002);
    start_copy(15'h0040, 15'h0041, 16'd3);
    wait_done(nbusy, got);
    check("t7_done_seen", got, 1'b1);
    @(negedge clk);
    check("t7_ovl1", ram[15'h0041], 32'hD000_0000);
    check("t7_ovl2", ram[15'h0042], 32'hD000_0000);
    check("t7_ovl3", ram[15'h0043], 32'hD000_0000);

`ifdef COPY_ENGINE_CHECKSUM_EN
    preload(15'h0070, 32'h0000_0001);
    preload(15'h0071, 32'h0000_0002);
    preload(15'h0072, 32'h0000_0003);
    preload(15'h0073, 32'hFFFF_FFFF);
    start_copy(15'h0070, 15'h0600, 16'd4);
    check("t6_checksum_cleared", checksum, 32'h0);
    wait_done(nbusy, got);
    check("t6_done_seen", got, 1'b1);
    check("t6_checksum", checksum, 32'h0000_0005);
    @(negedge clk);
    check("t6_checksum_hold", checksum, 32'h0000_0005);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
